// File: rtl/wb_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_pkg
// Shared pipeline parameters for the register-file write-back path: the
// write-back type encodings, the default long-latency (LL) type code, the
// default starvation limit and the LL buffer entry type.
// -----------------------------------------------------------------------------
package wb_port_arbiter_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 64;

    // Write-back type 2'b00 means "no register-file write this cycle".
    localparam logic [1:0] WB_IDLE          = 2'b00;
    localparam logic [1:0] LL_TYPE_DEF      = 2'b01;
    localparam int         STARVE_LIMIT_DEF = 8;

    typedef logic [REG_W-1:0]  reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef struct packed {
        reg_addr_t des;
        reg_data_t data;
    } ll_entry_t;

    function automatic logic is_write(input logic [1:0] wb_type);
        return wb_type != WB_IDLE;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_if
// Bundles the main-pipeline write-back request, the LL result handshake and
// the shared register-file write port.
//   master : the producer side (pipeline + LL unit + register file view)
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic [1:0] PIPE_TYPE;
    reg_addr_t  PIPE_DES;
    reg_data_t  PIPE_DATA;
    logic       LL_VALID;
    reg_addr_t  LL_DES;
    reg_data_t  LL_DATA;
    logic       LL_READY;
    logic [1:0] WB_TYPE;
    reg_addr_t  WB_DES;
    reg_data_t  WB_DATA;
    logic       STALL_REQ;

    modport master (
        output PIPE_TYPE, PIPE_DES, PIPE_DATA, LL_VALID, LL_DES, LL_DATA,
        input  LL_READY, WB_TYPE, WB_DES, WB_DATA, STALL_REQ
    );

    modport slave (
        input  PIPE_TYPE, PIPE_DES, PIPE_DATA, LL_VALID, LL_DES, LL_DATA,
        output LL_READY, WB_TYPE, WB_DES, WB_DATA, STALL_REQ
    );

endinterface

// File: rtl/wb_ll_fifo.sv
// -----------------------------------------------------------------------------
// wb_ll_fifo
// DEPTH-entry buffer of LL results. Each entry carries a killed flag that is
// set when a younger pipeline write targets the same destination.
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_entry  : enqueue (ignored when full)
//   pop               : dequeue head (ignored when empty)
//   kill_en, kill_des : mark every stored entry with des == kill_des killed
//   full, empty       : occupancy flags
//   head, head_killed : current head entry and its killed flag
// -----------------------------------------------------------------------------
module wb_ll_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  ll_entry_t push_entry,
    input  logic      pop,
    input  logic      kill_en,
    input  reg_addr_t kill_des,
    output logic      full,
    output logic      empty,
    output ll_entry_t head,
    output logic      head_killed
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    ll_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic      [DEPTH-1:0] killed_q, killed_d;
    logic      [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic      [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic      [CNT_W-1:0] count_q, count_d;
    logic                  do_push, do_pop;

    // Pointers wrap modulo DEPTH, so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign head        = mem_q[rd_ptr_q];
    assign head_killed = killed_q[rd_ptr_q];
    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        killed_d = killed_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Stale slots may get marked too; a push always clears its slot's flag.
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && (mem_q[i].des == kill_des)) killed_d[i] = 1'b1;
        end
        if (do_push) begin
            mem_d[wr_ptr_q]    = push_entry;
            killed_d[wr_ptr_q] = 1'b0;
            wr_ptr_d           = ptr_inc(wr_ptr_q);
        end
        if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            killed_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            killed_q <= killed_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single register-file write port between the main pipeline
// (absolute priority) and buffered long-latency (mul/div) results.
//   CLK, RST : clock, asynchronous active-low reset
//   bus      : PIPE_* write request, LL_* result handshake (LL_READY = not
//              full), registered WB_* write port, registered STALL_REQ asking
//              the pipeline to idle when a buffered result starves.
// -----------------------------------------------------------------------------
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int         DEPTH        = 2,
    parameter int         STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter logic [1:0] LL_TYPE      = LL_TYPE_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    wb_port_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic       fifo_full, fifo_empty, head_killed;
    ll_entry_t  head, push_entry;
    logic       pipe_wr, pipe_kill, ll_accept, push, pop, pop_write;

    logic [1:0]       wb_type_q, wb_type_d;
    reg_addr_t        wb_des_q, wb_des_d;
    reg_data_t        wb_data_q, wb_data_d;
    logic             stall_q, stall_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    always_comb begin
        pipe_wr   = is_write(bus.PIPE_TYPE);
        pipe_kill = pipe_wr && (bus.PIPE_DES != '0);
        ll_accept = bus.LL_VALID && !fifo_full;
        // x0 results and results overwritten by a same-cycle pipeline write
        // are acknowledged but never buffered.
        push      = ll_accept && (bus.LL_DES != '0) &&
                    !(pipe_kill && (bus.PIPE_DES == bus.LL_DES));
        // A killed head drains even while the pipeline owns the port.
        pop       = !fifo_empty && (head_killed || !pipe_wr);
        pop_write = pop && !head_killed;
        push_entry.des  = bus.LL_DES;
        push_entry.data = bus.LL_DATA;
    end

    wb_ll_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (CLK),
        .rst_n       (RST),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .kill_en     (pipe_kill),
        .kill_des    (bus.PIPE_DES),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head        (head),
        .head_killed (head_killed)
    );

    always_comb begin
        wb_type_d = WB_IDLE;
        wb_des_d  = wb_des_q;
        wb_data_d = wb_data_q;
        if (pipe_wr) begin
            wb_type_d = bus.PIPE_TYPE;
            wb_des_d  = bus.PIPE_DES;
            wb_data_d = bus.PIPE_DATA;
        end else if (pop_write) begin
            wb_type_d = LL_TYPE;
            wb_des_d  = head.des;
            wb_data_d = head.data;
        end

        // Counts cycles a live head is left waiting; saturates at the limit.
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (!head_killed && (starve_q < CNT_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + CNT_W'(1);
        end
        stall_d = (starve_q >= CNT_W'(STARVE_LIMIT)) && !pop;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wb_type_q <= WB_IDLE;
            wb_des_q  <= '0;
            wb_data_q <= '0;
            stall_q   <= 1'b0;
            starve_q  <= '0;
        end else begin
            wb_type_q <= wb_type_d;
            wb_des_q  <= wb_des_d;
            wb_data_q <= wb_data_d;
            stall_q   <= stall_d;
            starve_q  <= starve_d;
        end
    end

    assign bus.LL_READY  = !fifo_full;
    assign bus.WB_TYPE   = wb_type_q;
    assign bus.WB_DES    = wb_des_q;
    assign bus.WB_DATA   = wb_data_q;
    assign bus.STALL_REQ = stall_q;

endmodule
